// File: rtl/run_control_pkg.sv
// Shared types and default widths for the run/halt/single-step sequencer.
package run_control_pkg;

   localparam int PC_WIDTH          = 4;
   localparam int STEP_WIDTH        = 8;
   localparam int COUNT_WIDTH       = 16;
   localparam int RESET_HOLD_CYCLES = 2;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      HALTED   = 2'd1,
      RUNNING  = 2'd2,
      STEPPING = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      NONE        = 3'd0,
      HOST        = 3'd1,
      BREAKPOINT  = 3'd2,
      STEP_DONE   = 3'd3,
      RESET_INSTR = 3'd4
   } halt_reason_t;

endpackage

// File: rtl/run_controller_if.sv
// Host/debug and CPU-side signals of the run controller. The master side is the
// host plus CPU core; the slave side is the controller itself.
interface run_controller_if #(
   parameter int PC_WIDTH    = run_control_pkg::PC_WIDTH,
   parameter int STEP_WIDTH  = run_control_pkg::STEP_WIDTH,
   parameter int COUNT_WIDTH = run_control_pkg::COUNT_WIDTH
);
   logic                   runRequest;
   logic                   haltRequest;
   logic                   stepRequest;
   logic [STEP_WIDTH-1:0]  stepCount;
   logic                   breakpointEnable;
   logic [PC_WIDTH-1:0]    breakpointPc;
   logic                   clearCount;
   logic [PC_WIDTH-1:0]    pc;
   logic                   cpuIsReset;
   logic                   cpuEnable;
   logic                   cpuResetN;
   logic [1:0]             state;
   logic [2:0]             haltReason;
   logic [COUNT_WIDTH-1:0] retiredCount;

   modport master (
      output runRequest, haltRequest, stepRequest, stepCount,
      output breakpointEnable, breakpointPc, clearCount, pc, cpuIsReset,
      input  cpuEnable, cpuResetN, state, haltReason, retiredCount
   );

   modport slave (
      input  runRequest, haltRequest, stepRequest, stepCount,
      input  breakpointEnable, breakpointPc, clearCount, pc, cpuIsReset,
      output cpuEnable, cpuResetN, state, haltReason, retiredCount
   );
endinterface

// File: rtl/breakpoint_unit.sv
// PC breakpoint compare with a one-shot skip so a breakpointed instruction can
// be executed once when the core is resumed from that breakpoint.
module breakpoint_unit #(
   parameter int PC_WIDTH = 4
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic                breakpointEnable,
   input  logic [PC_WIDTH-1:0] breakpointPc,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                setSkip,
   input  logic                cpuEnable,
   output logic                bpHit
);
   logic skipBp;

   // Arm the skip on resume from a breakpoint; drop it once an instruction retires.
   always_ff @(posedge clock) begin
      if (!resetN)
         skipBp <= 1'b0;
      else if (setSkip)
         skipBp <= 1'b1;
      else if (cpuEnable)
         skipBp <= 1'b0;
   end

   assign bpHit = breakpointEnable && (pc == breakpointPc) && !skipBp;
endmodule

// File: rtl/run_controller.sv
// Run/halt/single-step sequencer: holds the CPU in reset after power-up, gates
// execution per cycle, halts on host/breakpoint/step/RESET-instruction events
// and counts retired instructions.
module run_controller #(
   parameter int PC_WIDTH          = run_control_pkg::PC_WIDTH,
   parameter int STEP_WIDTH        = run_control_pkg::STEP_WIDTH,
   parameter int COUNT_WIDTH       = run_control_pkg::COUNT_WIDTH,
   parameter int RESET_HOLD_CYCLES = run_control_pkg::RESET_HOLD_CYCLES
) (
   input logic             clock,
   input logic             resetN,
   run_controller_if.slave bus
);
   import run_control_pkg::*;

   localparam logic [1:0] ST_HOLD     = HOLD;
   localparam logic [1:0] ST_HALTED   = HALTED;
   localparam logic [1:0] ST_RUNNING  = RUNNING;
   localparam logic [1:0] ST_STEPPING = STEPPING;

   localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

   logic [1:0]             stateReg;
   logic [HOLD_W-1:0]      holdCnt;
   logic [STEP_WIDTH-1:0]  remaining;
   logic [2:0]             reasonReg;
   logic [COUNT_WIDTH-1:0] retiredReg;
   logic                   active;
   logic                   cpuEnable;
   logic                   bpHit;
   logic                   setSkip;

   breakpoint_unit #(.PC_WIDTH(PC_WIDTH)) u_bp (
      .clock            (clock),
      .resetN           (resetN),
      .breakpointEnable (bus.breakpointEnable),
      .breakpointPc     (bus.breakpointPc),
      .pc               (bus.pc),
      .setSkip          (setSkip),
      .cpuEnable        (cpuEnable),
      .bpHit            (bpHit)
   );

   // Execution gate and resume-from-breakpoint detection.
   always_comb begin
      active    = (stateReg == ST_RUNNING) || (stateReg == ST_STEPPING);
      cpuEnable = active && !bpHit;
      setSkip   = (stateReg == ST_HALTED) && !bus.haltRequest &&
                  (bus.stepRequest || bus.runRequest) && (reasonReg == BREAKPOINT);
   end

   // Controller FSM with reset-hold timer, step budget and halt-reason capture.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         stateReg  <= ST_HOLD;
         holdCnt   <= '0;
         remaining <= '0;
         reasonReg <= NONE;
      end else begin
         case (stateReg)
            ST_HOLD: begin
               if (holdCnt == HOLD_LAST) begin
                  stateReg  <= ST_HALTED;
                  reasonReg <= NONE;
               end else begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end
            ST_HALTED: begin
               if (!bus.haltRequest) begin
                  if (bus.stepRequest) begin
                     remaining <= (bus.stepCount == '0) ? STEP_WIDTH'(1) : bus.stepCount;
                     stateReg  <= ST_STEPPING;
                  end else if (bus.runRequest) begin
                     stateReg <= ST_RUNNING;
                  end
               end
            end
            default: begin
               if ((stateReg == ST_STEPPING) && cpuEnable)
                  remaining <= remaining - 1'b1;
               if (bus.haltRequest) begin
                  stateReg  <= ST_HALTED;
                  reasonReg <= HOST;
               end else if (bpHit) begin
                  stateReg  <= ST_HALTED;
                  reasonReg <= BREAKPOINT;
               end else if (cpuEnable && bus.cpuIsReset) begin
                  stateReg  <= ST_HALTED;
                  reasonReg <= RESET_INSTR;
               end else if ((stateReg == ST_STEPPING) && cpuEnable &&
                            (remaining == STEP_WIDTH'(1))) begin
                  stateReg  <= ST_HALTED;
                  reasonReg <= STEP_DONE;
               end
            end
         endcase
      end
   end

   // Retired-instruction counter; clear beats increment, wraps naturally.
   always_ff @(posedge clock) begin
      if (!resetN)
         retiredReg <= '0;
      else if (bus.clearCount)
         retiredReg <= '0;
      else if (cpuEnable)
         retiredReg <= retiredReg + 1'b1;
   end

   assign bus.cpuEnable    = cpuEnable;
   assign bus.cpuResetN    = (stateReg != ST_HOLD);
   assign bus.state        = stateReg;
   assign bus.haltReason   = reasonReg;
   assign bus.retiredCount = retiredReg;
endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a toy CPU whose pc advances on cpuEnable, a vector
// table of start/halt scenarios, a halt scoreboard and hand-written corner cases.
module tb_run_controller;
   import run_control_pkg::*;

   typedef struct {
      logic [15:0] ret;
      logic [2:0]  reason;
      logic [3:0]  pc;
      string       tag;
   } exp_t;

   typedef struct {
      int kind;      // 0 step, 1 run, 2 step+run together
      int cnt;
      bit clr;
      bit bpEn;
      int bpPc;
      bit rstEn;
      int expRet;
      int expReason;
      int expPc;
   } vec_t;

   logic clock  = 1'b0;
   logic resetN = 1'b0;
   logic pcClear = 1'b0;
   logic rstInstrEn = 1'b0;
   logic [3:0] rstInstrPc = 4'd6;
   int checks = 0;
   int errors = 0;
   exp_t sbq[$];
   vec_t vecs[12];
   logic [1:0] prevState = 2'd0;

   always #5 clock = ~clock;

   run_controller_if bus();

   run_controller dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   // Toy CPU: pc cleared while held in reset, advances on each executed instruction.
   always @(posedge clock) begin
      if (!bus.cpuResetN || pcClear)
         bus.pc <= 4'd0;
      else if (bus.cpuEnable)
         bus.pc <= bus.pc + 4'd1;
   end

   assign bus.cpuIsReset = rstInstrEn && (bus.pc == rstInstrPc);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every entry into HALTED from execution pops one expectation.
   always @(negedge clock) begin
      exp_t e;
      if (bus.state == 2'd1 && (prevState == 2'd2 || prevState == 2'd3)) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_halt: reason %0d with no pending expectation", bus.haltReason);
         end else begin
            e = sbq.pop_front();
            check({e.tag, "_retired"}, 32'(bus.retiredCount), 32'(e.ret));
            check({e.tag, "_reason"}, 32'(bus.haltReason), 32'(e.reason));
            check({e.tag, "_pc"}, 32'(bus.pc), 32'(e.pc));
         end
      end
      prevState = bus.state;
   end

   task automatic clear_all();
      pcClear = 1'b1;
      bus.clearCount = 1'b1;
      @(negedge clock);
      pcClear = 1'b0;
      bus.clearCount = 1'b0;
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL halt_timeout: %0d pending after %0d cycles, expected 0", sbq.size(), n);
         sbq.delete();
      end
      @(negedge clock);
   endtask

   // Called at the negedge where resetN has just been raised.
   task automatic check_hold(input string tag);
      int low = 0;
      bit sawEn = 1'b0;
      while (bus.cpuResetN == 1'b0 && low < 20) begin
         if (bus.cpuEnable) sawEn = 1'b1;
         low++;
         @(negedge clock);
      end
      check({tag, "_hold_cycles"}, 32'(low), 32'(RESET_HOLD_CYCLES));
      check({tag, "_state_halted"}, 32'(bus.state), 32'd1);
      check({tag, "_reason_none"}, 32'(bus.haltReason), 32'd0);
      check({tag, "_no_enable_in_hold"}, 32'(sawEn), 32'd0);
   endtask

   initial begin
      int n;
      bus.runRequest = 1'b0;
      bus.haltRequest = 1'b0;
      bus.stepRequest = 1'b0;
      bus.stepCount = 8'd0;
      bus.breakpointEnable = 1'b0;
      bus.breakpointPc = 4'd0;
      bus.clearCount = 1'b0;

      //          kind cnt  clr   bpEn  bp  rstEn  ret rsn pc
      vecs[0]  = '{0,   5,  1'b1, 1'b0, 0,  1'b0,  5,  3,  5};
      vecs[1]  = '{0,   0,  1'b1, 1'b0, 0,  1'b0,  1,  3,  1};
      vecs[2]  = '{1,   0,  1'b1, 1'b1, 3,  1'b0,  3,  2,  3};
      vecs[3]  = '{0,   1,  1'b0, 1'b1, 3,  1'b0,  4,  3,  4};
      vecs[4]  = '{0,   3,  1'b1, 1'b1, 1,  1'b0,  1,  2,  1};
      vecs[5]  = '{1,   0,  1'b0, 1'b1, 1,  1'b0, 17,  2,  1};
      vecs[6]  = '{0, 255,  1'b1, 1'b1, 10, 1'b0, 10,  2, 10};
      vecs[7]  = '{2,   2,  1'b1, 1'b0, 0,  1'b0,  2,  3,  2};
      vecs[8]  = '{1,   0,  1'b1, 1'b0, 0,  1'b1,  7,  4,  7};
      vecs[9]  = '{0,   4,  1'b1, 1'b0, 0,  1'b1,  4,  3,  4};
      vecs[10] = '{0,   7,  1'b1, 1'b0, 0,  1'b1,  7,  4,  7};
      vecs[11] = '{0,   5,  1'b1, 1'b1, 0,  1'b0,  0,  2,  0};

      // Power-up reset
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_cpuResetN", 32'(bus.cpuResetN), 32'd0);
      check("rst_cpuEnable", 32'(bus.cpuEnable), 32'd0);
      check("rst_reason", 32'(bus.haltReason), 32'd0);
      check("rst_retired", 32'(bus.retiredCount), 32'd0);
      resetN = 1'b1;
      check_hold("por");

      // Table-driven start/halt scenarios
      for (int i = 0; i < 12; i++) begin
         bus.breakpointEnable = vecs[i].bpEn;
         bus.breakpointPc = 4'(vecs[i].bpPc);
         rstInstrEn = vecs[i].rstEn;
         if (vecs[i].clr) clear_all();
         sbq.push_back('{16'(vecs[i].expRet), 3'(vecs[i].expReason), 4'(vecs[i].expPc),
                         $sformatf("vec%0d", i)});
         bus.stepCount = 8'(vecs[i].cnt);
         bus.stepRequest = (vecs[i].kind != 1);
         bus.runRequest = (vecs[i].kind != 0);
         @(negedge clock);
         bus.stepRequest = 1'b0;
         bus.runRequest = 1'b0;
         check($sformatf("vec%0d_start_state", i), 32'(bus.state),
               (vecs[i].kind == 1) ? 32'd2 : 32'd3);
         wait_halt(400);
      end
      bus.breakpointEnable = 1'b0;
      rstInstrEn = 1'b0;

      // haltRequest in HALTED outranks stepRequest: nothing starts
      bus.haltRequest = 1'b1;
      bus.stepRequest = 1'b1;
      bus.stepCount = 8'd3;
      @(negedge clock);
      bus.haltRequest = 1'b0;
      bus.stepRequest = 1'b0;
      check("halted_haltreq_ignored_state", 32'(bus.state), 32'd1);
      check("halted_haltreq_ignored_enable", 32'(bus.cpuEnable), 32'd0);

      // Host halt while running: request cycle retires one more instruction
      clear_all();
      bus.runRequest = 1'b1;
      @(negedge clock);
      bus.runRequest = 1'b0;
      check("host_run_state", 32'(bus.state), 32'd2);
      repeat (3) @(negedge clock);
      sbq.push_back('{16'd4, 3'd1, 4'd4, "host_halt"});
      bus.haltRequest = 1'b1;
      @(negedge clock);
      bus.haltRequest = 1'b0;
      check("host_halt_enable_off", 32'(bus.cpuEnable), 32'd0);
      wait_halt(5);

      // clearCount beats the increment of a retiring cycle
      clear_all();
      bus.runRequest = 1'b1;
      @(negedge clock);
      bus.runRequest = 1'b0;
      repeat (3) @(negedge clock);
      sbq.push_back('{16'd0, 3'd1, 4'd4, "clear_vs_retire"});
      bus.haltRequest = 1'b1;
      bus.clearCount = 1'b1;
      @(negedge clock);
      bus.haltRequest = 1'b0;
      bus.clearCount = 1'b0;
      wait_halt(5);

      // Reset in the middle of a step burst
      clear_all();
      bus.stepCount = 8'd200;
      bus.stepRequest = 1'b1;
      @(negedge clock);
      bus.stepRequest = 1'b0;
      repeat (4) @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      check("midrst_state", 32'(bus.state), 32'd0);
      check("midrst_retired", 32'(bus.retiredCount), 32'd0);
      check("midrst_enable", 32'(bus.cpuEnable), 32'd0);
      check("midrst_cpuResetN", 32'(bus.cpuResetN), 32'd0);
      resetN = 1'b1;
      check_hold("midrst");

      // Counter wrap: run to 16'hFFFE, then step two more
      clear_all();
      bus.runRequest = 1'b1;
      @(negedge clock);
      bus.runRequest = 1'b0;
      n = 0;
      while (bus.retiredCount !== 16'hFFFD && n < 70000) begin
         @(negedge clock);
         n++;
      end
      if (bus.retiredCount === 16'hFFFD) begin
         sbq.push_back('{16'hFFFE, 3'd1, 4'hE, "wrap_preload"});
         bus.haltRequest = 1'b1;
         @(negedge clock);
         bus.haltRequest = 1'b0;
         wait_halt(5);
         sbq.push_back('{16'h0000, 3'd3, 4'h0, "wrap"});
         bus.stepCount = 8'd2;
         bus.stepRequest = 1'b1;
         @(negedge clock);
         bus.stepRequest = 1'b0;
         wait_halt(10);
      end else begin
         checks++;
         errors++;
         $display("FAIL wrap_preload_timeout: retiredCount %0h expected fffd", bus.retiredCount);
         bus.haltRequest = 1'b1;
         @(negedge clock);
         bus.haltRequest = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
